palette_engine: RTL and testbench

Programmable palette stage that sits between the per-pixel colour-index generator (character/sprite ROM lookups) and the VGA DAC outputs. It replaces a fixed, load-time palette table with a writable palette RAM, per-frame colour cycling over a configurable index range, and a stepped fade-to-level brightness scaler. It has a 2-cycle pixel pipeline and is parametrised in index width, channel width and fade resolution.

---
 rtl/palette_engine.sv | 194 +++++++++++++++++++
 tb/tb_palette_engine.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/palette_engine.sv
// palette_engine
//   Programmable palette stage between the colour-index generator and the
//   VGA DAC. A writable palette RAM, per-frame colour cycling over an index
//   range, and a stepped fade-to-level brightness scaler, in a 2-cycle
//   pipeline.
//
//   Fade states (derived from lvl vs clamped fade_target):
//     state  | meaning
//     F_HOLD | lvl equals target, fade_done high
//     F_UP   | lvl below target, +1 per frame_tick
//     F_DOWN | lvl above target, -1 per frame_tick
//
// Ports
//   clk, rst_n                 pixel clock, async active-low reset
//   color, color_valid         pixel index and display enable
//   r, g, b, out_valid         scaled registered colour, valid delayed 2 cycles
//   wr_en, wr_addr, wr_data    palette write port, wr_data = {r,g,b}
//   frame_tick                 one pulse per frame
//   cycle_en, cycle_lo/hi      colour-cycling enable and inclusive range
//   cycle_period               frame ticks per rotation step, minus 1
//   fade_target, fade_done     target brightness and reached flag
module palette_engine #(
    parameter int IDX_W  = 3,
    parameter int CH_W   = 6,
    parameter int FADE_W = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [IDX_W-1:0]    color,
    input  logic                color_valid,
    output logic [CH_W-1:0]     r,
    output logic [CH_W-1:0]     g,
    output logic [CH_W-1:0]     b,
    output logic                out_valid,
    input  logic                wr_en,
    input  logic [IDX_W-1:0]    wr_addr,
    input  logic [3*CH_W-1:0]   wr_data,
    input  logic                frame_tick,
    input  logic                cycle_en,
    input  logic [IDX_W-1:0]    cycle_lo,
    input  logic [IDX_W-1:0]    cycle_hi,
    input  logic [7:0]          cycle_period,
    input  logic [FADE_W:0]     fade_target,
    output logic                fade_done
);

    localparam int NUM = 2 ** IDX_W;
    localparam int PW  = CH_W + FADE_W + 1;
    localparam logic [FADE_W:0] FULL = (FADE_W + 1)'(1 << FADE_W);

    typedef enum logic [1:0] {
        F_HOLD,
        F_UP,
        F_DOWN
    } fade_state_t;

    // Grey ramp: index bits replicated MSB-first across the channel width.
    function automatic logic [CH_W-1:0] grey(input int i);
        logic [IDX_W-1:0] iv;
        logic [CH_W-1:0]  res;
        iv = IDX_W'(i);
        res = '0;
        for (int j = 0; j < CH_W; j++) begin
            res[CH_W-1-j] = iv[IDX_W-1-(j % IDX_W)];
        end
        return res;
    endfunction

    function automatic logic [CH_W-1:0] scale(input logic [CH_W-1:0] c,
                                              input logic [FADE_W:0] l);
        return CH_W'((PW'(c) * PW'(l)) >> FADE_W);
    endfunction

    logic [3*CH_W-1:0] pal [NUM];
    logic [IDX_W-1:0]  rot;
    logic [7:0]        cnt;
    logic [FADE_W:0]   lvl;
    logic [FADE_W:0]   lvl_nxt;
    logic [FADE_W:0]   target_c;
    fade_state_t       fade_state;

    logic [IDX_W-1:0]  idx1;
    logic              valid1;

    logic [IDX_W:0]    span;
    logic              range_ok;
    logic              in_range;
    logic [IDX_W:0]    sum;
    logic [IDX_W:0]    mapped;
    logic [IDX_W-1:0]  idx;
    logic [3*CH_W-1:0] entry;

    // ---------------- palette RAM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM; i++) begin
                pal[i] <= {grey(i), grey(i), grey(i)};
            end
        end else if (wr_en) begin
            pal[wr_addr] <= wr_data;
        end
    end

    // ---------------- colour cycling ----------------
    assign range_ok = (cycle_lo <= cycle_hi);
    assign span     = {1'b0, cycle_hi} - {1'b0, cycle_lo} + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rot <= '0;
            cnt <= '0;
        end else if (!cycle_en) begin
            rot <= '0;
            cnt <= '0;
        end else if (frame_tick) begin
            if (cnt == cycle_period) begin
                cnt <= '0;
                // An inverted range freezes the rotation offset.
                if (range_ok) begin
                    if ({1'b0, rot} >= span - 1'b1) rot <= '0;
                    else                            rot <= rot + 1'b1;
                end
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // rot may exceed a freshly shrunk span; mapping stays identity until wrap.
    assign in_range = cycle_en && range_ok && (color >= cycle_lo) &&
                      (color <= cycle_hi) && ({1'b0, rot} < span);
    assign sum      = {1'b0, color} + {1'b0, rot};
    assign mapped   = (sum > {1'b0, cycle_hi}) ? (sum - span) : sum;
    assign idx      = in_range ? IDX_W'(mapped) : color;

    // ---------------- fade ----------------
    assign target_c = (fade_target > FULL) ? FULL : fade_target;

    always_comb begin
        fade_state = F_HOLD;
        lvl_nxt    = lvl;
        if (lvl < target_c)      fade_state = F_UP;
        else if (lvl > target_c) fade_state = F_DOWN;
        if (frame_tick) begin
            case (fade_state)
                F_UP:    lvl_nxt = lvl + 1'b1;
                F_DOWN:  lvl_nxt = lvl - 1'b1;
                default: lvl_nxt = lvl;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) lvl <= FULL;
        else        lvl <= lvl_nxt;
    end

    assign fade_done = (fade_state == F_HOLD);

    // ---------------- pixel pipeline ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx1   <= '0;
            valid1 <= 1'b0;
        end else begin
            idx1   <= idx;
            valid1 <= color_valid;
        end
    end

    // Flop-based RAM: a write on this edge is not yet visible to this read.
    assign entry = pal[idx1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r         <= '0;
            g         <= '0;
            b         <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= valid1;
            if (valid1) begin
                r <= scale(entry[3*CH_W-1:2*CH_W], lvl);
                g <= scale(entry[2*CH_W-1:CH_W], lvl);
                b <= scale(entry[CH_W-1:0], lvl);
            end else begin
                r <= '0;
                g <= '0;
                b <= '0;
            end
        end
    end

endmodule

// File: tb/tb_palette_engine.sv
module tb_palette_engine;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  color = '0;
    logic        color_valid = 1'b0;
    logic [5:0]  r, g, b;
    logic        out_valid;
    logic        wr_en = 1'b0;
    logic [2:0]  wr_addr = '0;
    logic [17:0] wr_data = '0;
    logic        frame_tick = 1'b0;
    logic        cycle_en = 1'b0;
    logic [2:0]  cycle_lo = '0;
    logic [2:0]  cycle_hi = '0;
    logic [7:0]  cycle_period = '0;
    logic [4:0]  fade_target = 5'd16;
    logic        fade_done;

    int checks = 0;
    int failures = 0;
    bit run_chk = 0;

    palette_engine dut (
        .clk(clk), .rst_n(rst_n),
        .color(color), .color_valid(color_valid),
        .r(r), .g(g), .b(b), .out_valid(out_valid),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .frame_tick(frame_tick), .cycle_en(cycle_en),
        .cycle_lo(cycle_lo), .cycle_hi(cycle_hi), .cycle_period(cycle_period),
        .fade_target(fade_target), .fade_done(fade_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int m_r[8], m_g[8], m_b[8];
    int m_rot, m_cnt, m_lvl, m_idx1;
    bit m_v1;
    int e_r, e_g, e_b;
    bit e_v;

    function automatic int tgt_clamped();
        return (fade_target > 16) ? 16 : int'(fade_target);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            m_r[i] = i * 9; m_g[i] = i * 9; m_b[i] = i * 9;
        end
        m_rot = 0; m_cnt = 0; m_lvl = 16; m_idx1 = 0; m_v1 = 0;
        e_r = 0; e_g = 0; e_b = 0; e_v = 0;
    endtask

    function automatic int map_color(input int c);
        int lo, hi, span;
        lo = cycle_lo; hi = cycle_hi; span = hi - lo + 1;
        if (cycle_en && lo <= hi && c >= lo && c <= hi && m_rot < span)
            return lo + ((c - lo + m_rot) % span);
        return c;
    endfunction

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                model_reset();
            end else begin
                int span, t;
                e_v = m_v1;
                e_r = m_v1 ? m_r[m_idx1] * m_lvl / 16 : 0;
                e_g = m_v1 ? m_g[m_idx1] * m_lvl / 16 : 0;
                e_b = m_v1 ? m_b[m_idx1] * m_lvl / 16 : 0;
                m_idx1 = map_color(int'(color));
                m_v1 = color_valid;
                if (wr_en) begin
                    m_r[wr_addr] = int'(wr_data[17:12]);
                    m_g[wr_addr] = int'(wr_data[11:6]);
                    m_b[wr_addr] = int'(wr_data[5:0]);
                end
                span = int'(cycle_hi) - int'(cycle_lo) + 1;
                if (!cycle_en) begin
                    m_rot = 0; m_cnt = 0;
                end else if (frame_tick) begin
                    if (m_cnt == int'(cycle_period)) begin
                        m_cnt = 0;
                        if (span > 0) m_rot = (m_rot >= span - 1) ? 0 : m_rot + 1;
                    end else begin
                        m_cnt = (m_cnt + 1) % 256;
                    end
                end
                if (frame_tick) begin
                    t = tgt_clamped();
                    if (m_lvl < t) m_lvl++;
                    else if (m_lvl > t) m_lvl--;
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (run_chk && rst_n) begin
                check("model_r", r, e_r);
                check("model_g", g, e_g);
                check("model_b", b, e_b);
                check("model_out_valid", out_valid, e_v);
                check("model_fade_done", fade_done, m_lvl == tgt_clamped());
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    int grey_tab[8] = '{0, 9, 18, 27, 36, 45, 54, 63};

    // ---------------- stimulus ----------------
    initial begin
        step();
        step();
        check("reset_r", r, 0);
        check("reset_out_valid", out_valid, 0);
        check("reset_fade_done", fade_done, 1);
        rst_n = 1'b1;
        run_chk = 1;
        step();

        // grey ramp through the pipeline
        color_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            color = 3'(i);
            step();
            if (i > 0) check("ramp_r", r, grey_tab[i-1]);
        end
        step();
        check("ramp_r7", r, grey_tab[7]);

        // write/read collision on entry 3
        color = 3'd3;
        step();
        wr_en = 1'b1; wr_addr = 3'd3; wr_data = {6'd63, 6'd0, 6'd21};
        step();
        wr_en = 1'b0;
        check("collide_old_r", r, 27);
        check("collide_old_g", g, 27);
        step();
        check("collide_new_r", r, 63);
        check("collide_new_g", g, 0);
        check("collide_new_b", b, 21);

        // colour cycling over 2..5
        cycle_en = 1'b1; cycle_lo = 3'd2; cycle_hi = 3'd5; cycle_period = 8'd0;
        step();
        frame_tick = 1'b1;
        step(); step(); step();
        frame_tick = 1'b0;
        color = 3'd2; step(); step();
        check("cycle_2to5_r", r, 45);
        color = 3'd4; step(); step();
        check("cycle_4to3_r", r, 63);
        check("cycle_4to3_b", b, 21);
        color = 3'd6; step(); step();
        check("cycle_6_r", r, 54);
        frame_tick = 1'b1; step(); frame_tick = 1'b0;
        color = 3'd2; step(); step();
        check("cycle_wrap_r", r, 18);

        // fade to black
        cycle_en = 1'b0;
        fade_target = 5'd0;
        color = 3'd7;
        step(); step();
        check("fade_start_done", fade_done, 0);
        frame_tick = 1'b1; step(); frame_tick = 1'b0;
        step();
        check("fade_first_step_r", r, 59);
        for (int i = 0; i < 14; i++) begin
            frame_tick = 1'b1; step();
        end
        frame_tick = 1'b0;
        check("fade_15_done", fade_done, 0);
        frame_tick = 1'b1; step(); frame_tick = 1'b0;
        check("fade_16_done", fade_done, 1);
        step(); step();
        check("fade_black_r", r, 0);

        // rise toward 8, reset mid-fade
        fade_target = 5'd8;
        frame_tick = 1'b1;
        step(); step(); step(); step();
        frame_tick = 1'b0;
        step(); step();
        check("fade_lvl4_r", r, 15);
        #1 rst_n = 1'b0;
        #1;
        check("async_reset_r", r, 0);
        check("async_reset_valid", out_valid, 0);
        check("async_reset_done", fade_done, 0);
        #3 rst_n = 1'b1;
        step(); step();
        check("post_reset_r", r, 63);
        color = 3'd3; step(); step();
        check("post_reset_ramp3", g, 27);

        // blanking slot
        color = 3'd1; step();
        color = 3'd6; color_valid = 1'b0; step();
        color_valid = 1'b1; step();
        check("blank_valid", out_valid, 0);
        check("blank_r", r, 0);
        step();
        check("after_blank_r", r, 54);
        check("after_blank_valid", out_valid, 1);

        // randomized traffic, including clamped targets and inverted ranges
        for (int n = 0; n < 2000; n++) begin
            color        = 3'($urandom_range(0, 7));
            color_valid  = ($urandom_range(0, 9) != 0);
            wr_en        = ($urandom_range(0, 9) == 0);
            wr_addr      = 3'($urandom_range(0, 7));
            wr_data      = 18'($urandom);
            frame_tick   = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 49) == 0) cycle_en = ~cycle_en;
            if ($urandom_range(0, 99) == 0) begin
                cycle_lo = 3'($urandom_range(0, 7));
                cycle_hi = 3'($urandom_range(0, 7));
                cycle_period = 8'($urandom_range(0, 3));
            end
            if ($urandom_range(0, 79) == 0) fade_target = 5'($urandom_range(0, 31));
            step();
        end
        frame_tick = 1'b0;
        wr_en = 1'b0;
        step(); step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
